// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the programmable counter family.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Prescaler register width: enough bits for 0..prescale-1, never narrower than 1.
    function automatic int prescale_w(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

    function automatic bit params_ok(input int width, input int prescale);
        return (width >= 2) && (width <= 64) && (prescale >= 1) && (prescale <= 65535);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step every PRESCALE enabled cycles; clr restarts the count.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_direct
            logic unused_in;
            assign unused_in = ^{clk, rst, clr};
            assign step      = en;
        end else begin : g_div
            localparam int PW = prescale_w(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pcnt;

            // en low freezes the partial count rather than restarting it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pcnt <= '0;
                end else if (clr) begin
                    pcnt <= '0;
                end else if (en) begin
                    pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
                end
            end

            assign step = en && (pcnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with modulus, prescaler, wrap/saturate, tc pulse and sticky overflow.
module counter_prog
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf_sticky
);

    localparam logic [WIDTH:0] MAX_X     = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] RANGE_TOP = {1'b1, {WIDTH{1'b0}}};

    generate
        if (!params_ok(WIDTH, PRESCALE)) begin : g_bad_params
            $error("counter_prog: WIDTH must be 2..64 and PRESCALE 1..65535");
        end
        if (INIT > MAX_VAL) begin : g_bad_init
            $error("counter_prog: INIT exceeds MAX_VAL");
        end
        if ({1'b0, MAX_VAL} >= RANGE_TOP) begin : g_bad_max
            $error("counter_prog: MAX_VAL does not fit in WIDTH bits");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    logic           step;
    logic           boundary;
    logic [WIDTH:0] out_x;
    logic [WIDTH:0] nxt_x;
    logic           unused_msb;
    cnt_mode_e      mode;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (clr | load),
        .step(step)
    );

    // One extra bit keeps out+1 exact when MAX_VAL is the full range.
    always_comb begin
        out_x    = {1'b0, out};
        nxt_x    = out_x;
        boundary = 1'b0;
        mode     = cnt_mode_e'(sat_mode);
        if (clr) begin
            nxt_x = '0;
        end else if (load) begin
            nxt_x = {1'b0, clamp_max(load_val)};
        end else if (step) begin
            if (up_dn) begin
                boundary = (out_x == MAX_X);
                if (boundary) nxt_x = (mode == CNT_SAT) ? MAX_X : '0;
                else          nxt_x = out_x + (WIDTH+1)'(1);
            end else begin
                boundary = (out_x == '0);
                if (boundary) nxt_x = (mode == CNT_SAT) ? '0 : MAX_X;
                else          nxt_x = out_x - (WIDTH+1)'(1);
            end
        end
    end

    assign unused_msb = nxt_x[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out        <= INIT;
            tc         <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            out        <= nxt_x[WIDTH-1:0];
            tc         <= boundary;
            ovf_sticky <= boundary | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_counter_prog.sv
// Self-checking bench: two counter_prog instances (PRESCALE 1 and 3) against a behavioural model.
module tb_counter_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       up_dn;
    logic       sat_mode;
    logic       ovf_clr;
    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b, ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    counter_prog #(.WIDTH(4), .MAX_VAL(4'd9), .INIT(4'd3), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .out(out_a), .tc(tc_a), .ovf_sticky(ovf_a)
    );

    counter_prog #(.WIDTH(4), .MAX_VAL(4'd9), .INIT(4'd0), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .up_dn(up_dn), .sat_mode(sat_mode), .ovf_clr(ovf_clr),
        .out(out_b), .tc(tc_b), .ovf_sticky(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pc;
        bit tc;
        bit ovf;
    } mst_t;

    mst_t ma, mb;

    // Counter behaviour stated directly: count in 0..maxv, one step per p enabled cycles.
    function automatic mst_t mstep(mst_t s, int maxv, int p, bit en_i, bit clr_i, bit load_i,
                                   int lv, bit up_i, bit sat_i, bit oc);
        mst_t n   = s;
        bit   bnd = 1'b0;
        if (clr_i) begin
            n.cnt = 0;
            n.pc  = 0;
        end else if (load_i) begin
            n.cnt = (lv > maxv) ? maxv : lv;
            n.pc  = 0;
        end else if (en_i) begin
            n.pc = (s.pc + 1) % p;
            if (s.pc == p - 1) begin
                if (up_i) begin
                    if (s.cnt == maxv) begin bnd = 1'b1; n.cnt = sat_i ? maxv : 0; end
                    else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == 0) begin bnd = 1'b1; n.cnt = sat_i ? 0 : maxv; end
                    else n.cnt = s.cnt - 1;
                end
            end
        end
        n.tc  = bnd;
        n.ovf = bnd || (s.ovf && !oc);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{cnt: 3, pc: 0, tc: 1'b0, ovf: 1'b0};
            mb <= '{cnt: 0, pc: 0, tc: 1'b0, ovf: 1'b0};
        end else begin
            ma <= mstep(ma, 9, 1, en, clr, load, int'(load_val), up_dn, sat_mode, ovf_clr);
            mb <= mstep(mb, 9, 3, en, clr, load, int'(load_val), up_dn, sat_mode, ovf_clr);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_out_a", longint'(out_a), longint'(ma.cnt));
            chk("model_tc_a",  longint'(tc_a),  longint'(ma.tc));
            chk("model_ovf_a", longint'(ovf_a), longint'(ma.ovf));
            chk("model_out_b", longint'(out_b), longint'(mb.cnt));
            chk("model_tc_b",  longint'(tc_b),  longint'(mb.tc));
            chk("model_ovf_b", longint'(ovf_b), longint'(mb.ovf));
        end
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_in(input bit e, input bit c, input bit l, input logic [3:0] lv,
                          input bit u, input bit s, input bit oc);
        en = e; clr = c; load = l; load_val = lv; up_dn = u; sat_mode = s; ovf_clr = oc;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 4'd0, 1, 0, 0);
        #1 rst = 1'b1;
        cyc(2);
        run = 1'b1;
        chk("reset_out_a", longint'(out_a), 3);
        chk("reset_tc_a",  longint'(tc_a),  0);
        chk("reset_ovf_a", longint'(ovf_a), 0);
        chk("reset_out_b", longint'(out_b), 0);
        rst = 1'b0;

        // up, wrap through 0..9,0
        set_in(0, 1, 0, 4'd0, 1, 0, 0);
        cyc();
        set_in(1, 0, 0, 4'd0, 1, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("wrap_count", longint'(out_a), i);
        end
        chk("wrap_no_tc_at_max", longint'(tc_a), 0);
        cyc();
        chk("wrap_out_zero", longint'(out_a), 0);
        chk("wrap_tc",       longint'(tc_a),  1);
        chk("wrap_ovf",      longint'(ovf_a), 1);
        cyc();
        chk("wrap_tc_one_cycle", longint'(tc_a), 0);

        // down, saturate from 1
        set_in(0, 0, 1, 4'd1, 0, 1, 1);
        cyc();
        chk("sat_load_1",  longint'(out_a), 1);
        chk("sat_ovf_clr", longint'(ovf_a), 0);
        set_in(1, 0, 0, 4'd0, 0, 1, 0);
        cyc();
        chk("sat_out_0",   longint'(out_a), 0);
        chk("sat_tc_0",    longint'(tc_a),  0);
        cyc();
        chk("sat_hold_0",  longint'(out_a), 0);
        chk("sat_tc_1",    longint'(tc_a),  1);
        cyc();
        chk("sat_hold_0b", longint'(out_a), 0);
        chk("sat_tc_2",    longint'(tc_a),  1);

        // prescaler on dut_b
        set_in(0, 1, 0, 4'd0, 1, 0, 0);
        cyc();
        set_in(1, 0, 0, 4'd0, 1, 0, 0);
        cyc(2);
        chk("pre_not_yet", longint'(out_b), 0);
        cyc();
        chk("pre_one",     longint'(out_b), 1);
        cyc(3);
        chk("pre_two",     longint'(out_b), 2);
        en = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(2);
        chk("pre_delayed", longint'(out_b), 2);
        cyc();
        chk("pre_three",   longint'(out_b), 3);

        // load clamp and clr priority
        set_in(0, 0, 1, 4'd15, 1, 0, 0);
        cyc();
        chk("load_clamp",    longint'(out_a), 9);
        chk("load_no_tc",    longint'(tc_a),  0);
        set_in(0, 1, 1, 4'd5, 1, 0, 0);
        cyc();
        chk("clr_over_load", longint'(out_a), 0);

        // ovf_clr against simultaneous boundary step
        set_in(0, 0, 0, 4'd0, 1, 1, 1);
        cyc();
        chk("ovf_clear",      longint'(ovf_a), 0);
        set_in(0, 0, 1, 4'd9, 1, 1, 0);
        cyc();
        set_in(1, 0, 0, 4'd0, 1, 1, 1);
        cyc();
        chk("ovf_set_wins",   longint'(ovf_a), 1);
        chk("ovf_sat_hold",   longint'(out_a), 9);
        chk("ovf_sat_tc",     longint'(tc_a),  1);
        set_in(0, 0, 0, 4'd0, 1, 1, 1);
        cyc();
        chk("ovf_clear_alone", longint'(ovf_a), 0);

        // asynchronous reset mid-count
        set_in(0, 1, 0, 4'd0, 1, 0, 0);
        cyc();
        set_in(1, 0, 0, 4'd0, 1, 0, 0);
        cyc(5);
        chk("pre_rst_count", longint'(out_a), 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", longint'(out_a), 3);
        chk("async_rst_tc",  longint'(tc_a),  0);
        chk("async_rst_ovf", longint'(ovf_a), 0);
        cyc();
        rst = 1'b0;

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst      = ($urandom_range(0, 249) == 0);
            en       = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            ovf_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) up_dn    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sat_mode = 1'($urandom_range(0, 1));
        end
        cyc();
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
